// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   One on-chip word memory shared by NUM_PORTS masters through a
//   round-robin arbiter. Only one transaction is in flight at a time.
//   Timing: a request seen in IDLE is granted, the access runs LATENCY
//   cycles later, and memReady pulses in the following RESP cycle.
//
// Ports
//   clk, reset          clock / synchronous active-high reset
//   address             per-port byte address, port p at [p*ADDR_W +: ADDR_W]
//   datain              per-port write data (32 bits each)
//   wen, ren            per-port level requests (wen wins when both are set)
//   byte_select_vector  per-port write byte lanes (4 bits each)
//   memReady            one-cycle completion pulse per port
//   dataout             per-port read data, updated in the memReady cycle, then held
//   err                 one-cycle out-of-range pulse, coincident with memReady
//   grant_cnt           per-port 16-bit completed-transaction counters
//
// Build option
//   MEM_ARB_PERF_EN  defined: grant_cnt counters present.
//                    undefined: grant_cnt tied to 0, no counter flops.

module mem_port_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS*ADDR_W-1:0] address,
   input  logic [NUM_PORTS*32-1:0]     datain,
   input  logic [NUM_PORTS-1:0]        wen,
   input  logic [NUM_PORTS-1:0]        ren,
   input  logic [NUM_PORTS*4-1:0]      byte_select_vector,
   output logic [NUM_PORTS-1:0]        memReady,
   output logic [NUM_PORTS*32-1:0]     dataout,
   output logic [NUM_PORTS-1:0]        err,
   output logic [NUM_PORTS*16-1:0]     grant_cnt
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                       state_q, state_d;
   logic [PW-1:0]                rr_q, rr_d;
   logic [PW-1:0]                gnt_q, gnt_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [ADDR_W-1:0]            addr_q, addr_d;
   logic [31:0]                  wdata_q, wdata_d;
   logic [3:0]                   be_q, be_d;
   logic                         we_q, we_d;
   logic                         re_q, re_d;
   logic [NUM_PORTS-1:0]         rdy_q, rdy_d;
   logic [NUM_PORTS-1:0]         err_q, err_d;
   logic [NUM_PORTS-1:0][31:0]   dout_q, dout_d;

   logic [31:0]                  mem_q [DEPTH_WORDS];

   logic [NUM_PORTS-1:0]         req;
   logic                         req_any;
   logic [PW-1:0]                pick;
   logic [PW-1:0]                idx;
   logic [AW-1:0]                widx;
   logic                         oor;
   logic                         access;
   logic                         mem_we;
   logic                         unused_addr_lsb;

   assign req = ren | wen;

   // Round-robin: first requester at or after rr_q, wrapping.
   always_comb begin
      req_any = 1'b0;
      pick    = '0;
      idx     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = PW'((int'(rr_q) + i) % NUM_PORTS);
         if (!req_any && req[idx]) begin
            req_any = 1'b1;
            pick    = idx;
         end
      end
   end

   assign widx            = addr_q[2 +: AW];
   // Any word-address bit above the memory index means out of range.
   assign oor             = (addr_q[ADDR_W-1:2] >> AW) != '0;
   assign access          = (state_q == BUSY) && (cnt_q == '0);
   // Reset on the access edge aborts the write.
   assign mem_we          = access && we_q && !oor && !reset;
   assign unused_addr_lsb = ^addr_q[1:0];

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      re_d    = re_q;
      rdy_d   = '0;
      err_d   = '0;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               gnt_d   = pick;
               addr_d  = address[int'(pick)*ADDR_W +: ADDR_W];
               wdata_d = datain[int'(pick)*32 +: 32];
               be_d    = byte_select_vector[int'(pick)*4 +: 4];
               we_d    = wen[pick];
               re_d    = ren[pick];
               cnt_d   = CW'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d      = RESP;
               rdy_d[gnt_q] = 1'b1;
               err_d[gnt_q] = oor;
               if (we_q) begin
                  // Write with ren also set reports zero; a plain write leaves dataout alone.
                  if (re_q) dout_d[gnt_q] = '0;
               end else begin
                  dout_d[gnt_q] = oor ? 32'h0 : mem_q[widx];
               end
            end
         end
         RESP: begin
            state_d = IDLE;
            rr_d    = (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         rdy_q   <= '0;
         err_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         re_q    <= re_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   // Storage is not reset; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem_q[widx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [NUM_PORTS-1:0][15:0] gcnt_q, gcnt_d;

   // Counts move on the same edge that raises memReady; 16-bit wrap.
   always_comb begin
      gcnt_d = gcnt_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rdy_d[p]) gcnt_d[p] = gcnt_q[p] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) gcnt_q <= '0;
      else       gcnt_q <= gcnt_d;
   end

   assign grant_cnt = gcnt_q;
`else
   assign grant_cnt = '0;
`endif

   assign memReady = rdy_q;
   assign err      = err_q;
   assign dataout  = dout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (NUM_PORTS=2, LATENCY=2, DEPTH_WORDS=1024).
// Reference model: associative word array, per-port dataout/counter copies
// and a round-robin pointer, all updated from the behavioural rules.
module tb_mem_port_arbiter;
   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [NP*32-1:0] address;
   logic [NP*32-1:0] datain;
   logic [NP-1:0]    wen, ren;
   logic [NP*4-1:0]  byte_select_vector;
   logic [NP-1:0]    memReady, err;
   logic [NP*32-1:0] dataout;
   logic [NP*16-1:0] grant_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] ref_mem [int];
   logic [31:0] ref_dout [NP];
   logic [15:0] ref_cnt [NP];
   int          ref_rr;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .address(address), .datain(datain), .wen(wen), .ren(ren),
      .byte_select_vector(byte_select_vector), .memReady(memReady), .dataout(dataout),
      .err(err), .grant_cnt(grant_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_gcnt();
`ifdef MEM_ARB_PERF_EN
      return {ref_cnt[1], ref_cnt[0]};
`else
      return 32'h0;
`endif
   endfunction

   task automatic model_reset();
      ref_rr = 0;
      for (int p = 0; p < NP; p++) begin
         ref_dout[p] = 32'h0;
         ref_cnt[p]  = 16'h0;
      end
   endtask

   // Applies one completed transaction to the model; returns expected err.
   task automatic model_txn(input int p, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, output bit e);
      logic [31:0] m;
      int          wi;
      wi = int'(a >> 2);
      e  = (a >> 2) >= 32'd1024;
      if (w) begin
         if (!e) begin
            m = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = d[8*b +: 8];
            ref_mem[wi] = m;
         end
         if (r) ref_dout[p] = 32'h0;
      end else begin
         ref_dout[p] = e ? 32'h0 : ref_mem[wi];
      end
      ref_cnt[p] = ref_cnt[p] + 16'd1;
      ref_rr     = (p + 1) % NP;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_dout0"}, dataout[31:0], ref_dout[0]);
      chk({tag, "_dout1"}, dataout[63:32], ref_dout[1]);
      chk({tag, "_gcnt"}, grant_cnt, exp_gcnt());
   endtask

   // Single-master transaction from an idle arbiter.
   task automatic do_txn(input string tag, input int p, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int n;
      bit e;
      address[p*32 +: 32]          = a;
      datain[p*32 +: 32]           = d;
      byte_select_vector[p*4 +: 4] = be;
      ren[p] = r;
      wen[p] = w;
      n = 0;
      do begin
         tick();
         n++;
      end while (memReady == '0 && n < 20);
      model_txn(p, r, w, a, d, be, e);
      chk({tag, "_lat"}, 32'(n), 32'd3);
      chk({tag, "_rdy"}, 32'(memReady), 32'(1) << p);
      chk({tag, "_err"}, 32'(err), 32'(e) << p);
      check_outs(tag);
      ren = '0;
      wen = '0;
      tick();
      chk({tag, "_rdy_off"}, 32'(memReady), 32'h0);
   endtask

   initial begin
      int g, n;
      bit e;
      logic [31:0] a;
      address = '0; datain = '0; wen = '0; ren = '0; byte_select_vector = '0;
      model_reset();

      // Reset held two cycles: all outputs zero.
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_rdy", 32'(memReady), 32'h0);
         chk("rst_err", 32'(err), 32'h0);
         chk("rst_dout", dataout[31:0] | dataout[63:32], 32'h0);
         chk("rst_gcnt", grant_cnt, 32'h0);
      end
      reset = 1'b0;
      tick();

      // Fill a 16-word window so later reads are defined.
      for (int i = 0; i < 16; i++) do_txn("init", 1, 0, 1, i * 4, $urandom, 4'hF);

      do_txn("w_dead", 1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      do_txn("r_dead", 0, 1, 0, 32'h10, 32'h0, 4'h0);
      chk("dead_val", dataout[31:0], 32'hDEADBEEF);

      do_txn("w_lane", 1, 0, 1, 32'h10, 32'h000000AA, 4'b0001);
      do_txn("r_lane", 0, 1, 0, 32'h13, 32'h0, 4'h0);
      chk("lane_val", dataout[31:0], 32'hDEADBEAA);

      do_txn("w_nolane", 1, 0, 1, 32'h10, 32'h55555555, 4'b0000);
      do_txn("r_nolane", 0, 1, 0, 32'h10, 32'h0, 4'h0);

      // Both ports read continuously: grants follow the rr pointer.
      address = {32'h8, 32'h10};
      ren = 2'b11;
      for (int k = 0; k < 4; k++) begin
         g = ref_rr;
         n = 0;
         do begin
            tick();
            n++;
         end while (memReady == '0 && n < 20);
         model_txn(g, 1, 0, address[g*32 +: 32], 32'h0, 4'h0, e);
         chk("alt_gap", 32'(n), (k == 0) ? 32'd3 : 32'd4);
         chk("alt_rdy", 32'(memReady), 32'(1) << g);
         check_outs("alt");
      end
      ren = '0;
      tick();
      tick();

      // Out of range read and write; the write must not alias word 4.
      do_txn("oor_rd", 0, 1, 0, 32'h1000, 32'h0, 4'h0);
      chk("oor_rd_val", dataout[31:0], 32'h0);
      do_txn("oor_wr", 1, 0, 1, 32'h1010, 32'h11111111, 4'hF);
      do_txn("oor_chk", 0, 1, 0, 32'h10, 32'h0, 4'h0);
      chk("oor_keep", dataout[31:0], 32'hDEADBEAA);
      do_txn("top_wr", 1, 0, 1, 32'hFFC, 32'hCAFEF00D, 4'hF);
      do_txn("top_rd", 0, 1, 0, 32'hFFC, 32'h0, 4'h0);
      do_txn("both", 1, 1, 1, 32'h18, 32'hA5A5A5A5, 4'hF);

      // Reset on the access edge of a P1 write: nothing completes, nothing written.
      address[63:32] = 32'h20; datain[63:32] = 32'h12345678; byte_select_vector[7:4] = 4'hF;
      wen[1] = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      wen = '0;
      tick();
      chk("abort_rdy", 32'(memReady), 32'h0);
      reset = 1'b0;
      model_reset();
      tick();
      chk("abort_rdy2", 32'(memReady), 32'h0);
      check_outs("abort");
      do_txn("abort_rd", 0, 1, 0, 32'h20, 32'h0, 4'h0);

      // 5 P0 + 3 P1 transactions after reset.
      for (int i = 1; i < 5; i++) do_txn("cnt0", 0, 1, 0, i * 4, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) do_txn("cnt1", 1, 1, 0, i * 4, 32'h0, 4'h0);
`ifdef MEM_ARB_PERF_EN
      chk("gcnt_5_3", grant_cnt, {16'd3, 16'd5});
`else
      chk("gcnt_off", grant_cnt, 32'h0);
`endif

      // Randomised traffic over the window plus occasional out-of-range addresses.
      for (int i = 0; i < 40; i++) begin
         int op;
         op = $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom_range(0, 15) << 2);
         else a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         do_txn("rnd", $urandom_range(0, 1), op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
